pulse_stretcher: RTL

- Converts single-cycle `tick` pulses into a level pulse of fixed width.
- Enforces a minimum low (guard) time between output pulses.
- Queues one tick that arrives while busy; reports ticks lost beyond that.
- Sits downstream of edge detectors and timers to drive LEDs, enables and strobes that need multi-cycle assertion.

---
 rtl/pulse_stretcher_pkg.sv | 19 +
 rtl/pulse_stretcher.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// the down-counter width derivation.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    GUARD = 2'd2
  } ps_state_e;

  // The counter must hold the larger of the two reload values (cycles - 1),
  // so size it for max(HIGH_CYCLES, LOW_CYCLES) + 1 distinct values.
  function automatic int ps_cnt_width(input int high_cycles, input int low_cycles);
    int m;
    m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle ticks into HIGH_CYCLES-wide level pulses separated by at
// least LOW_CYCLES low cycles; one tick may queue while busy. Optional macro:
// PULSE_STRETCHER_RETRIGGER_EN (ticks during HIGH extend the current pulse).
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic level,
  output logic busy,
  output logic dropped
);

  localparam int CNT_W = ps_cnt_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CNT_W-1:0] LP_HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE       = CNT_W'(1);

  ps_state_e        r_state;
  ps_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             r_level;
  logic             r_dropped;
  logic             w_dropped_nxt;
  logic             w_cnt_zero;
  logic             w_queue;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_dropped_nxt = 1'b0;
    w_queue       = 1'b0;

    case (r_state)
      IDLE: begin
        if (tick) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = LP_HIGH_LOAD;
        end
      end

      HIGH: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (tick) begin
          w_cnt_nxt = LP_HIGH_LOAD;
        end else if (w_cnt_zero) begin
          w_state_nxt = GUARD;
          w_cnt_nxt   = LP_LOW_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - LP_ONE;
        end
`else
        // Even the final HIGH cycle counts as busy, so its tick is queued.
        w_queue = tick;
        if (w_cnt_zero) begin
          w_state_nxt = GUARD;
          w_cnt_nxt   = LP_LOW_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - LP_ONE;
        end
`endif
      end

      GUARD: begin
        if (w_cnt_zero) begin
          if (r_pending || tick) begin
            // Serve the queued tick; a fresh tick now takes its place in the queue.
            w_state_nxt   = HIGH;
            w_cnt_nxt     = LP_HIGH_LOAD;
            w_pending_nxt = r_pending && tick;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - LP_ONE;
          w_queue   = tick;
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_cnt_nxt     = '0;
        w_pending_nxt = 1'b0;
      end
    endcase

    if (w_queue) begin
      if (r_pending) begin
        w_dropped_nxt = 1'b1;
      end else begin
        w_pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_level   <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_level   <= (w_state_nxt == HIGH);
      r_dropped <= w_dropped_nxt;
    end
  end

  assign level   = r_level;
  assign busy    = (r_state != IDLE);
  assign dropped = r_dropped;

endmodule
